// File: rtl/neuron_pkg.sv
// Shared types and default sizing for the neuron MAC block.
package neuron_pkg;

    localparam int unsigned DEF_DW    = 10;
    localparam int unsigned DEF_WW    = 10;
    localparam int unsigned DEF_AW    = 24;
    localparam int unsigned DEF_N_IN  = 20;
    localparam int unsigned DEF_SCALE = 1000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Beat counter width; a one-beat frame still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scaled_mul.sv
// Combinational sign-magnitude multiply of an unsigned activation by a signed weight,
// divided by SCALE (truncated toward zero) and re-signed.
module scaled_mul
    import neuron_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned WW    = DEF_WW,
    parameter int unsigned SCALE = DEF_SCALE
) (
    input  logic [DW-1:0]         data,
    input  logic signed [WW-1:0]  weight,
    output logic signed [DW+WW:0] term
);

    localparam int unsigned PW = DW + WW + 1;
    localparam logic [PW-1:0] SCALE_V = PW'(SCALE);

    logic          neg;
    logic [WW:0]   w_ext;
    logic [WW:0]   w_mag;
    logic [PW-1:0] prod;
    logic [PW-1:0] mag;

    always_comb begin
        neg   = weight[WW-1];
        // One extra bit so the most negative weight has a representable magnitude.
        w_ext = {weight[WW-1], weight};
        w_mag = neg ? (~w_ext + 1'b1) : w_ext;
        prod  = PW'(data) * PW'(w_mag);
        mag   = prod / SCALE_V;
        term  = neg ? $signed(~mag + 1'b1) : $signed(mag);
    end

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate: sums N_IN scaled products per frame and presents the result.
// Optional saturation with sticky overflow flag: define NEURON_MAC_SAT_EN.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned WW    = DEF_WW,
    parameter int unsigned N_IN  = DEF_N_IN,
    parameter int unsigned SCALE = DEF_SCALE,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic signed [WW-1:0] in_weight,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] out_data,
    output logic                 out_ovf
);

    localparam int unsigned TW = DW + WW + 1;
    localparam int unsigned SW = ((AW > TW) ? AW : TW) + 1;
    localparam int unsigned CW = cnt_width(N_IN);
    localparam logic [CW-1:0] LAST = CW'(N_IN - 1);

    state_e                state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [TW-1:0]  term;
    logic signed [SW-1:0]  sum;
    logic signed [AW-1:0]  acc_sum;

    scaled_mul #(
        .DW    (DW),
        .WW    (WW),
        .SCALE (SCALE)
    ) u_scaled_mul (
        .data   (in_data),
        .weight (in_weight),
        .term   (term)
    );

    // Sum is wide enough that it can never itself overflow.
    assign sum = {{(SW-AW){acc_q[AW-1]}}, acc_q} + {{(SW-TW){term[TW-1]}}, term};

`ifdef NEURON_MAC_SAT_EN
    localparam logic signed [SW-1:0] ACC_MAX = {{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {{(SW-AW+1){1'b1}}, {(AW-1){1'b0}}};

    logic ovf_q, ovf_d;
    logic clamp;

    always_comb begin
        clamp   = 1'b0;
        acc_sum = sum[AW-1:0];
        if (sum > ACC_MAX) begin
            acc_sum = ACC_MAX[AW-1:0];
            clamp   = 1'b1;
        end else if (sum < ACC_MIN) begin
            acc_sum = ACC_MIN[AW-1:0];
            clamp   = 1'b1;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == StIdle && start) begin
            ovf_d = 1'b0;
        end else if (state_q == StAccum && in_valid) begin
            ovf_d = ovf_q | clamp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = out_valid & ovf_q;
`else
    logic unused_sum_hi;

    assign acc_sum       = sum[AW-1:0];
    assign unused_sum_hi = ^sum[SW-1:AW];
    assign out_ovf       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccum;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            StAccum: begin
                if (in_valid) begin
                    acc_d = acc_sum;
                    if (cnt_q == LAST) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StDone: begin
                // A coincident start is deliberately dropped here.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StAccum);
    assign out_valid = (state_q == StDone);
    assign out_data  = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench: two neuron_mac instances (wide 11-bit weight / AW=24, and 10-bit / AW=12)
// driven by shared stimulus, table-driven frames plus handshake, reset and start corner cases.
module tb_neuron_mac;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [9:0] in_data = '0;
    logic signed [10:0] w_a = '0;
    logic signed [9:0]  w_b;

    logic in_ready_a, out_valid_a, ovf_a;
    logic signed [23:0] out_data_a;
    logic in_ready_b, out_valid_b, ovf_b;
    logic signed [11:0] out_data_b;

    assign w_b = w_a[9:0];

    always #5 clk = ~clk;

    neuron_mac #(.DW(10), .WW(11), .N_IN(4), .SCALE(1000), .AW(24)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_data   (in_data),
        .in_weight (w_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_data  (out_data_a),
        .out_ovf   (ovf_a)
    );

    neuron_mac #(.DW(10), .WW(10), .N_IN(4), .SCALE(1000), .AW(12)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_data   (in_data),
        .in_weight (w_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_data  (out_data_b),
        .out_ovf   (ovf_b)
    );

    typedef struct packed {
        logic [3:0][9:0]  d;
        logic [3:0][10:0] w;
        int               ea;
        int               eb;
        logic             ob;
    } vec_t;

    typedef struct {
        int ea;
        int eb;
        bit ob;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input int d0, input int w0, input int d1, input int w1,
                                input int d2, input int w2, input int d3, input int w3,
                                input int ea, input int eb, input bit ob);
        vec_t v;
        v.d[0] = 10'(d0); v.w[0] = 11'(w0);
        v.d[1] = 10'(d1); v.w[1] = 11'(w1);
        v.d[2] = 10'(d2); v.w[2] = 11'(w2);
        v.d[3] = 10'(d3); v.w[3] = 11'(w3);
        v.ea = ea;
        v.eb = eb;
        v.ob = ob;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_ready_a"}, in_ready_a, 0);
        chk({name, "_valid_a"}, out_valid_a, 0);
        chk({name, "_data_a"}, out_data_a, 0);
        chk({name, "_ovf_a"}, ovf_a, 0);
        chk({name, "_ready_b"}, in_ready_b, 0);
        chk({name, "_valid_b"}, out_valid_b, 0);
        chk({name, "_data_b"}, out_data_b, 0);
        chk({name, "_ovf_b"}, ovf_b, 0);
    endtask

    // Waits (bounded) for the result, holds out_ready low for 'hold' cycles checking stability,
    // then accepts; optionally pulses start together with out_ready.
    task automatic collect(input int hold, input bit start_done);
        exp_t e;
        int   k = 0;
        while (!out_valid_a && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        chk("out_valid_seen", out_valid_a, 1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        e = sb.pop_front();
        for (int c = 0; c <= hold; c++) begin
            if (c == hold) begin
                out_ready = 1'b1;
                start     = start_done;
            end
            @(negedge clk);
            chk("done_data_a", out_data_a, e.ea);
            chk("done_ovf_a", ovf_a, 0);
            chk("done_data_b", out_data_b, e.eb);
            chk("done_ovf_b", ovf_b, e.ob);
            chk("done_valid_b", out_valid_b, 1);
            chk("done_ready_a", in_ready_a, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        chk_idle_outputs("after_accept");
        @(posedge clk); #1;
        chk("idle_stays_a", in_ready_a, 0);
        chk("idle_stays_b", in_ready_b, 0);
    endtask

    task automatic run_frame(input vec_t v, input bit gap, input int hold, input bit start_mid,
                             input bit start_done);
        exp_t e;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v.d[i];
            w_a      = v.w[i];
            start    = start_mid && (i == 2);
            if (i == 3) begin
                e.ea = v.ea;
                e.eb = v.eb;
                e.ob = v.ob;
                sb.push_back(e);
            end
            @(negedge clk);
            chk("beat_ready_a", in_ready_a, 1);
            chk("beat_ready_b", in_ready_b, 1);
            @(posedge clk); #1;
            start = 1'b0;
            if (i < 3) chk("no_early_valid", out_valid_a, 0);
            if (gap && i == 0) begin
                // Garbage on the bus while not valid must be ignored.
                in_valid = 1'b0;
                in_data  = 10'd1023;
                w_a      = -11'sd512;
                repeat (2) begin
                    @(negedge clk);
                    chk("gap_ready", in_ready_a, 1);
                    chk("gap_no_valid", out_valid_b, 0);
                    @(posedge clk); #1;
                end
            end
        end
        in_valid = 1'b0;
        chk("latency_a", out_valid_a, 1);
        chk("latency_b", out_valid_b, 1);
        collect(hold, start_done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(500, 1000, 200, -500, 999, 1, 0, -512, 400, -112, 1'b0);
        vecs[1] = mk(1023, -512, 3, -1, 0, 0, 0, 0, -523, -523, 1'b0);
`ifdef NEURON_MAC_SAT_EN
        vecs[2] = mk(1023, 511, 1023, 511, 1023, 511, 1023, 511, 2088, 2047, 1'b1);
        vecs[4] = mk(1023, -512, 1023, -512, 1023, -512, 1023, -512, -2092, -2048, 1'b1);
`else
        vecs[2] = mk(1023, 511, 1023, 511, 1023, 511, 1023, 511, 2088, -2008, 1'b0);
        vecs[4] = mk(1023, -512, 1023, -512, 1023, -512, 1023, -512, -2092, 2004, 1'b0);
`endif
        vecs[3] = mk(1000, -1, 999, -1, 2, 500, 1023, -511, -522, -522, 1'b0);

        #2;
        chk_idle_outputs("reset");
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_no_start", in_ready_a, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], 1'b0, 0, 1'b0, 1'b0);
        end

        // Gapped input and back-pressured output.
        run_frame(vecs[1], 1'b1, 5, 1'b0, 1'b0);

        // start during ACCUM and together with out_ready in DONE.
        run_frame(vecs[0], 1'b0, 2, 1'b1, 1'b1);

        // Reset after two beats; asynchronous, mid-cycle.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[2].d[i];
            w_a      = vecs[2].w[i];
            @(posedge clk); #1;
        end
        in_data = vecs[2].d[2];
        w_a     = vecs[2].w[2];
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk_idle_outputs("held_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(vecs[3], 1'b0, 0, 1'b0, 1'b0);

        // Reset while a result is presented.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[1].d[i];
            w_a      = vecs[1].w[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_reset_valid", out_valid_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("done_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(vecs[0], 1'b0, 0, 1'b0, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
